// File: rtl/adder_stim_pkg.sv
// Shared types, vector order and expected-response model for the PMOD adder-board checker.
package adder_stim_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DUT_RST,
      APPLY,
      SETTLE,
      CHECK,
      PACE,
      FINISH
   } state_t;

   // Operand order {a,b} within one pass
   localparam logic [1:0] VEC_ORDER [0:3] = '{2'b00, 2'b01, 2'b10, 2'b11};

   // Returns {sum, carry, latch} the board should show for operands a,b
   function automatic logic [2:0] exp_resp(input logic a, input logic b, input logic latch_in);
      return {a ^ b, a & b, latch_in | (a & b)};
   endfunction

endpackage

// File: rtl/pmod_sync.sv
// N-bit two-flop synchroniser for asynchronous board sense lines.
// Latency: 2 cycles.
// Backpressure: none, free-running.
module pmod_sync #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/adder_pmod_stim_checker.sv
// Drives operand/runstop/reset pins into the PMOD adder board and checks its LED responses.
// Latency: one vector per STEP_DIV cycles; response sampled SETTLE_CYC+2 cycles after APPLY.
// Backpressure: none; start is ignored while a run is in progress.
module adder_pmod_stim_checker
   import adder_stim_pkg::*;
#(
   parameter int STEP_DIV   = 6_000_000,
   parameter int RST_CYC    = 4,
   parameter int SETTLE_CYC = 4,
   parameter int N_PASSES   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       pmod_a,
   output logic       pmod_b,
   output logic       pmod_runstop,
   output logic       pmod_rst,
   input  logic       sense_sum,
   input  logic       sense_carry,
   input  logic       sense_latch,
   output logic       busy,
   output logic       done,
   output logic [7:0] pass_cnt,
   output logic [7:0] fail_cnt,
   output logic       err,
   output logic [1:0] last_vec
);

   localparam logic [31:0] RST_LAST    = 32'(RST_CYC - 1);
   localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC + 1);
   localparam logic [31:0] STEP_LAST   = 32'(STEP_DIV - 1);
   localparam logic [7:0]  PASS_LAST   = 8'(N_PASSES - 1);

   state_t      state, state_d;
   logic [31:0] cnt;
   logic [31:0] step_cnt;
   logic [1:0]  idx, idx_d;
   logic [7:0]  pass_idx, pass_idx_d;
   logic [1:0]  vec_d;
   logic        exp_latch;
   logic [2:0]  sense_s;
   logic [2:0]  resp_exp;
   logic        match;

   pmod_sync #(.WIDTH(3)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({sense_sum, sense_carry, sense_latch}),
      .q     (sense_s)
   );

   assign resp_exp = exp_resp(pmod_a, pmod_b, exp_latch);
   assign match    = (sense_s == resp_exp);

   always_comb begin
      state_d    = state;
      idx_d      = idx;
      pass_idx_d = pass_idx;
      case (state)
         IDLE: begin
            if (start) begin
               state_d    = DUT_RST;
               idx_d      = 2'd0;
               pass_idx_d = 8'd0;
            end
         end
         DUT_RST: if (cnt == RST_LAST) state_d = APPLY;
         APPLY:   state_d = SETTLE;
         SETTLE:  if (cnt == SETTLE_LAST) state_d = CHECK;
         CHECK:   state_d = PACE;
         PACE: begin
            if (step_cnt == STEP_LAST) begin
               idx_d   = idx + 2'd1;
               state_d = APPLY;
               if (idx == 2'd3) begin
                  if (pass_idx == PASS_LAST) state_d = FINISH;
                  else                       pass_idx_d = pass_idx + 8'd1;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      vec_d = VEC_ORDER[idx_d];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         step_cnt     <= '0;
         idx          <= '0;
         pass_idx     <= '0;
         exp_latch    <= 1'b0;
         pmod_a       <= 1'b0;
         pmod_b       <= 1'b0;
         pmod_runstop <= 1'b1;
         pmod_rst     <= 1'b1;
         busy         <= 1'b0;
         done         <= 1'b0;
         pass_cnt     <= '0;
         fail_cnt     <= '0;
         err          <= 1'b0;
         last_vec     <= '0;
      end else begin
         state    <= state_d;
         idx      <= idx_d;
         pass_idx <= pass_idx_d;
         busy     <= (state_d != IDLE);
         done     <= (state_d == FINISH);
         cnt      <= (state_d == state && state != IDLE) ? cnt + 32'd1 : '0;

         // Step period is measured from each APPLY so vectors are evenly paced
         if (state_d == APPLY)   step_cnt <= '0;
         else if (state != IDLE) step_cnt <= step_cnt + 32'd1;

         if (state == IDLE && start) begin
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            err       <= 1'b0;
            exp_latch <= 1'b0;
            pmod_rst  <= 1'b1;
         end

         if (state == DUT_RST && state_d == APPLY) begin
            pmod_rst     <= 1'b0;
            pmod_runstop <= 1'b0;
         end

         if (state_d == APPLY) begin
            pmod_a <= vec_d[1];
            pmod_b <= vec_d[0];
         end

         if (state == CHECK) begin
            last_vec  <= {pmod_a, pmod_b};
            exp_latch <= resp_exp[0];
            if (match) begin
               if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
            end else begin
               if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
               err <= 1'b1;
            end
         end

         if (state_d == FINISH) begin
            pmod_runstop <= 1'b1;
            pmod_a       <= 1'b0;
            pmod_b       <= 1'b0;
         end
      end
   end

endmodule
